sobel_window_buffer: RTL and testbench

Streaming 3x3 neighbourhood generator sitting directly upstream of the Sobel kernel inside the gray/Sobel datapath. It accepts grayscale pixels in raster order (one per px_rdy_i strobe) and keeps two line buffers plus a 3x3 shift window. It emits one full 3x3 window per interior pixel, with a single-cycle valid strobe, so the kernel stage can compute gradients without storing image rows itself.

---
 rtl/gray_sobel_pkg.sv | 28 ++
 rtl/sobel_line_row_buffer.sv | 36 +++
 rtl/sobel_window_buffer.sv | 140 ++++++++++++++
 tb/tb_sobel_window_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sobel_pkg.sv
// Shared types and constants for the gray/Sobel datapath: pixel/window
// types, 3x3 tap indices and the window-buffer FSM encoding.
package gray_sobel_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int WIN_TAPS        = 9;

    // Raster order inside the 3x3 window: top row, middle row, bottom row.
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    typedef logic [PIXEL_WIDTH_DEF-1:0] pixel_t;
    typedef pixel_t [WIN_TAPS-1:0]      window_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_line_row_buffer.sv
// One image row of pixels held in flops: synchronous write, combinational
// read, both addressed by column.
module sobel_line_row_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int AW          = $clog2(IMG_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [PIXEL_WIDTH-1:0] wdata_i,
    output logic [PIXEL_WIDTH-1:0] rdata_o
);

    logic [IMG_WIDTH-1:0][PIXEL_WIDTH-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                if (we_i && addr_i == AW'(i)) mem_q[i] <= wdata_i;
            end
        end
    end

    // Decoded read keeps non-power-of-two widths free of out-of-range selects.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < IMG_WIDTH; i++) begin
            if (addr_i == AW'(i)) rdata_o = mem_q[i];
        end
    end

endmodule

// File: rtl/sobel_window_buffer.sv
// Raster-order pixel stream in, registered 3x3 neighbourhood out, one
// valid pulse per interior pixel (no border padding).
module sobel_window_buffer
    import gray_sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       frame_start_i,
    input  logic                       px_rdy_i,
    input  logic [PIXEL_WIDTH-1:0]     in_pixel_i,
    output logic [9*PIXEL_WIDTH-1:0]   window_o,
    output logic                       window_valid_o,
    output logic                       busy_o,
    output logic                       frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t                             state_q, state_d;
    logic [CW-1:0]                      col_q, col_d;
    logic [RW-1:0]                      row_q, row_d;
    logic [WIN_TAPS-1:0][PIXEL_WIDTH-1:0] win_q, win_d;
    logic                               valid_q, valid_d;

    logic                   accept;
    logic [CW-1:0]          acc_col;
    logic [RW-1:0]          acc_row;
    logic [PIXEL_WIDTH-1:0] lb0_rd, lb1_rd;

    // A start pulse forces the accepted pixel (if any) to be (0,0).
    always_comb begin
        accept  = px_rdy_i && (frame_start_i || state_q == S_ACTIVE);
        acc_col = frame_start_i ? '0 : col_q;
        acc_row = frame_start_i ? '0 : row_q;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_ACTIVE: state_d = S_ACTIVE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (frame_start_i) begin
            state_d = S_ACTIVE;
            col_d   = '0;
            row_d   = '0;
        end
        if (accept) begin
            if (acc_col == COL_LAST) begin
                col_d = '0;
                if (acc_row == ROW_LAST) begin
                    row_d   = '0;
                    state_d = S_DONE;
                end else begin
                    row_d = acc_row + RW'(1);
                end
            end else begin
                col_d = acc_col + CW'(1);
                row_d = acc_row;
            end
        end
    end

    always_comb begin
        win_d   = win_q;
        valid_d = accept && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
        if (accept) begin
            win_d[W_TL] = win_q[W_TC];
            win_d[W_TC] = win_q[W_TR];
            win_d[W_TR] = lb1_rd;
            win_d[W_ML] = win_q[W_MC];
            win_d[W_MC] = win_q[W_MR];
            win_d[W_MR] = lb0_rd;
            win_d[W_BL] = win_q[W_BC];
            win_d[W_BC] = win_q[W_BR];
            win_d[W_BR] = in_pixel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
        end
    end

    // lb0 holds the previous row, lb1 the one before; lb1 is fed from lb0's
    // pre-write value so both rows age together on each accept.
    sobel_line_row_buffer #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .IMG_WIDTH   (IMG_WIDTH),
        .AW          (CW)
    ) u_lb0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (accept),
        .addr_i  (acc_col),
        .wdata_i (in_pixel_i),
        .rdata_o (lb0_rd)
    );

    sobel_line_row_buffer #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .IMG_WIDTH   (IMG_WIDTH),
        .AW          (CW)
    ) u_lb1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (accept),
        .addr_i  (acc_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    assign window_o       = win_q;
    assign window_valid_o = valid_q;
    assign busy_o         = (state_q != S_IDLE);
    assign frame_done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench: a 4x4 instance for the main scenarios and a 5-wide,
// 3-high instance for throttled random input against a small image model.
module tb_sobel_window_buffer;

    logic clk;
    int   checks;
    int   failures;

    logic        rst_a, fs_a, rdy_a;
    logic [7:0]  pix_a;
    logic [71:0] win_a;
    logic        vld_a, busy_a, done_a;

    logic        rst_b, fs_b, rdy_b;
    logic [7:0]  pix_b;
    logic [71:0] win_b;
    logic        vld_b, busy_b, done_b;

    logic [71:0] win_log [4];

    sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
        .clk_i(clk), .reset_i(rst_a), .frame_start_i(fs_a), .px_rdy_i(rdy_a),
        .in_pixel_i(pix_a), .window_o(win_a), .window_valid_o(vld_a),
        .busy_o(busy_a), .frame_done_o(done_a)
    );

    sobel_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_b (
        .clk_i(clk), .reset_i(rst_b), .frame_start_i(fs_b), .px_rdy_i(rdy_b),
        .in_pixel_i(pix_b), .window_o(win_b), .window_valid_o(vld_b),
        .busy_o(busy_b), .frame_done_o(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] pack9(input logic [7:0] a0, a1, a2, a3, a4,
                                          a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // 4x4 frame with p(r,c)=r*4+c: window of the pixel accepted at (r,c).
    function automatic logic [71:0] exp4(input int r, input int c);
        logic [71:0] e;
        int v;
        e = '0;
        for (int k = 0; k < 9; k++) begin
            v = (r - 2 + k / 3) * 4 + (c - 2 + k % 3);
            e[k*8 +: 8] = v[7:0];
        end
        return e;
    endfunction

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        tick();
        checks++;
        if ({win_a, vld_a, busy_a, done_a} !== 75'd0) begin
            failures++;
            $display("FAIL reset_a: got win=%h v=%b b=%b d=%b expected all 0", win_a, vld_a, busy_a, done_a);
        end
        checks++;
        if ({win_b, vld_b, busy_b, done_b} !== 75'd0) begin
            failures++;
            $display("FAIL reset_b: got win=%h v=%b b=%b d=%b expected all 0", win_b, vld_b, busy_b, done_b);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_after_start: got %b expected 1", busy_a);
        end
        for (int i = 0; i < 7; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i + 1); tick();
        end
        rdy_a = 1'b0;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        checks++;
        if ({win_a, vld_a, busy_a, done_a} !== 75'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got win=%h v=%b b=%b d=%b expected all 0", win_a, vld_a, busy_a, done_a);
        end
        for (int i = 0; i < 16; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i); tick();
            checks++;
            if ({vld_a, busy_a, done_a} !== 3'b000) begin
                failures++;
                $display("FAIL midreset_ignored px%0d: got v/b/d=%b%b%b expected 000", i, vld_a, busy_a, done_a);
            end
        end
        rdy_a = 1'b0; tick();
    endtask

    task automatic test_basic_window;
        int n;
        logic ev;
        n = 0;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i); tick();
            ev = (i / 4 >= 2) && (i % 4 >= 2);
            checks++;
            if (vld_a !== ev) begin
                failures++;
                $display("FAIL basic_valid px%0d: got %b expected %b", i, vld_a, ev);
            end
            if (vld_a === 1'b1) begin
                if (n < 4) win_log[n] = win_a;
                n++;
                checks++;
                if (win_a !== exp4(i / 4, i % 4)) begin
                    failures++;
                    $display("FAIL basic_window px%0d: got %h expected %h", i, win_a, exp4(i / 4, i % 4));
                end
            end
            if (i == 10) begin
                checks++;
                if (win_a !== pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)) begin
                    failures++;
                    $display("FAIL basic_first_window: got %h expected %h", win_a, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
                end
            end
            if (i == 15) begin
                checks++;
                if (win_a !== pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin
                    failures++;
                    $display("FAIL basic_last_window: got %h expected %h", win_a, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
                end
            end
        end
        rdy_a = 1'b0; tick();
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL basic_window_count: got %0d expected 4", n);
        end
        checks++;
        if (win_a !== pack9(5, 6, 7, 9, 10, 11, 13, 14, 15) || vld_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold_after_frame: got %h v=%b expected %h v=0", win_a, vld_a, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end
    endtask

    task automatic test_row_wrap;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i); tick();
            if (i == 11) begin
                checks++;
                if (vld_a !== 1'b1 || win_a !== pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
                    failures++;
                    $display("FAIL wrap_px11: got v=%b %h expected v=1 %h", vld_a, win_a, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
                end
            end
            if (i == 12 || i == 13) begin
                checks++;
                if (vld_a !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_no_valid px%0d: got %b expected 0", i, vld_a);
                end
            end
        end
        rdy_a = 1'b0; tick();
    endtask

    task automatic test_frame_done;
        int n;
        n = 0;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i); tick();
            checks++;
            if (done_a !== (i == 15)) begin
                failures++;
                $display("FAIL done_pulse px%0d: got %b expected %b", i, done_a, (i == 15));
            end
            if (vld_a === 1'b1) begin
                checks++;
                if (n >= 4 || win_a !== win_log[n]) begin
                    failures++;
                    $display("FAIL done_repeat_window %0d: got %h expected first-frame window", n, win_a);
                end
                n++;
            end
            if (i == 15) begin
                checks++;
                if (vld_a !== 1'b1 || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL done_cycle: got v=%b busy=%b expected v=1 busy=1", vld_a, busy_a);
                end
            end
        end
        rdy_a = 1'b0; tick();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || vld_a !== 1'b0) begin
            failures++;
            $display("FAIL done_after: got b=%b d=%b v=%b expected 000", busy_a, done_a, vld_a);
        end
    endtask

    task automatic test_throttle;
        logic [7:0]  img [3][5];
        logic [71:0] e, held;
        logic        ev;
        int          n;
        n = 0;
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                img[r][c] = 8'($urandom_range(0, 255));
                rdy_b = 1'b1; pix_b = img[r][c]; tick(); rdy_b = 1'b0;
                ev = (r >= 2) && (c >= 2);
                checks++;
                if (vld_b !== ev) begin
                    failures++;
                    $display("FAIL throttle_valid (%0d,%0d): got %b expected %b", r, c, vld_b, ev);
                end
                if (ev) begin
                    n++;
                    for (int k = 0; k < 9; k++) e[k*8 +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
                    checks++;
                    if (win_b !== e) begin
                        failures++;
                        $display("FAIL throttle_window (%0d,%0d): got %h expected %h", r, c, win_b, e);
                    end
                end
                held = win_b;
                tick();
                checks++;
                if (vld_b !== 1'b0 || win_b !== held) begin
                    failures++;
                    $display("FAIL throttle_hold (%0d,%0d): got v=%b %h expected v=0 %h", r, c, vld_b, win_b, held);
                end
                tick();
            end
        end
        checks++;
        if (n !== 3 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL throttle_count: got n=%0d busy=%b expected n=3 busy=0", n, busy_b);
        end
    endtask

    task automatic test_restart_collision;
        int n;
        n = 0;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdy_a = 1'b1; pix_a = 8'(8'h50 + i); tick();
        end
        fs_a = 1'b1; rdy_a = 1'b1; pix_a = 8'hAA; tick(); fs_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || vld_a !== 1'b0) begin
            failures++;
            $display("FAIL restart_state: got busy=%b v=%b expected busy=1 v=0", busy_a, vld_a);
        end
        for (int i = 1; i < 16; i++) begin
            rdy_a = 1'b1; pix_a = 8'(i); tick();
            if (vld_a === 1'b1) n++;
            if (i == 10) begin
                checks++;
                if (vld_a !== 1'b1 || win_a !== pack9(8'hAA, 1, 2, 4, 5, 6, 8, 9, 10)) begin
                    failures++;
                    $display("FAIL restart_first_window: got v=%b %h expected v=1 %h", vld_a, win_a, pack9(8'hAA, 1, 2, 4, 5, 6, 8, 9, 10));
                end
            end
            if (i == 15) begin
                checks++;
                if (done_a !== 1'b1) begin
                    failures++;
                    $display("FAIL restart_done: got %b expected 1", done_a);
                end
            end
        end
        rdy_a = 1'b0; tick();
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL restart_window_count: got %0d expected 4", n);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_a = 1'b1; fs_a = 1'b0; rdy_a = 1'b0; pix_a = '0;
        rst_b = 1'b1; fs_b = 1'b0; rdy_b = 1'b0; pix_b = '0;
        tick();
        test_reset();
        test_reset_midframe();
        test_basic_window();
        test_row_wrap();
        test_frame_done();
        test_throttle();
        test_restart_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
